// File: rtl/permutation_engine_if.sv
// Handshake and configuration bundle for the permutation engine.
// The engine connects through the slave modport; the producer/consumer side
// connects through the master modport.
interface permutation_engine_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8
) ();
    localparam int SEL_W = $clog2(IN_W);
    localparam int IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    logic             i_cfg_we;
    logic [IDX_W-1:0] i_cfg_idx;
    logic [SEL_W-1:0] i_cfg_sel;
    logic             i_cfg_restore;
    logic             i_valid;
    logic             o_ready;
    logic [IN_W-1:0]  i_signal;
    logic             o_valid;
    logic             i_ready;
    logic [OUT_W-1:0] o_signal;

    modport master (
        output i_cfg_we, i_cfg_idx, i_cfg_sel, i_cfg_restore,
        output i_valid, i_signal, i_ready,
        input  o_ready, o_valid, o_signal
    );

    modport slave (
        input  i_cfg_we, i_cfg_idx, i_cfg_sel, i_cfg_restore,
        input  i_valid, i_signal, i_ready,
        output o_ready, o_valid, o_signal
    );
endinterface

// File: rtl/permutation_engine.sv
// Runtime-programmable bit permutation/expansion engine.
// Each output bit picks one input bit through a per-bit select table; the
// permuted word passes through a two-register valid/ready pipeline
// (stage A = permute, stage B = output holding register).
module permutation_engine #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8,
    localparam int SEL_W = $clog2(IN_W),
    localparam int IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1,
    parameter logic [OUT_W*SEL_W-1:0] DEFAULT_MAP = 16'h3993
) (
    input  logic i_clk,
    input  logic i_rst,
    permutation_engine_if.slave bus
);
    // Input word zero-extended to the full select range, so selects that
    // point past IN_W naturally read a 0.
    localparam int EXT_W = 1 << SEL_W;

    logic [SEL_W-1:0] map_q [OUT_W];

    logic             a_valid_q;
    logic [OUT_W-1:0] a_data_q;
    logic             b_valid_q;
    logic [OUT_W-1:0] b_data_q;

    logic [EXT_W-1:0] sig_ext;
    logic [OUT_W-1:0] perm_d;
    logic [IDX_W-1:0] cfg_idx;
    logic             b_adv;
    logic             a_ready;
    logic             accept;

    assign cfg_idx = bus.i_cfg_idx;

    // Stage B drains when empty or when downstream takes the word; stage A
    // can refill whenever it is empty or is itself moving into B.
    assign b_adv   = !b_valid_q || bus.i_ready;
    assign a_ready = !a_valid_q || b_adv;
    assign accept  = bus.i_valid && a_ready;

    // Permute the incoming word through the current (pre-edge) table.
    always_comb begin
        sig_ext = '0;
        sig_ext[IN_W-1:0] = bus.i_signal;
        perm_d = '0;
        for (int k = 0; k < OUT_W; k++) begin
            perm_d[k] = sig_ext[map_q[k]];
        end
    end

    // Select table: restore beats a single-entry write; out-of-range indices are dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_cfg_restore) begin
            for (int k = 0; k < OUT_W; k++) begin
                map_q[k] <= DEFAULT_MAP[k*SEL_W +: SEL_W];
            end
        end else if (bus.i_cfg_we && (int'(cfg_idx) < OUT_W)) begin
            map_q[cfg_idx] <= bus.i_cfg_sel;
        end
    end

    // Two-stage pipeline: A captures permuted words, B presents them downstream.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_valid_q <= 1'b0;
            a_data_q  <= '0;
            b_valid_q <= 1'b0;
            b_data_q  <= '0;
        end else begin
            if (a_ready) begin
                a_valid_q <= bus.i_valid;
                if (bus.i_valid) begin
                    a_data_q <= perm_d;
                end
            end
            if (b_adv) begin
                b_valid_q <= a_valid_q;
                if (a_valid_q) begin
                    b_data_q <= a_data_q;
                end
            end
        end
    end

    assign bus.o_ready  = a_ready;
    assign bus.o_valid  = b_valid_q;
    assign bus.o_signal = b_data_q;

    logic unused_accept;
    assign unused_accept = accept;
endmodule

// File: tb/tb_permutation_engine.sv
// Self-checking bench for permutation_engine: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_permutation_engine;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    permutation_engine_if #(.IN_W(4), .OUT_W(8)) ifa ();
    permutation_engine_if #(.IN_W(3), .OUT_W(6)) ifb ();

    permutation_engine #(.IN_W(4), .OUT_W(8)) dut8 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifa)
    );

    // Narrow instance: default table maps output k to input k%3.
    permutation_engine #(.IN_W(3), .OUT_W(6), .DEFAULT_MAP(12'h924)) dut3 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifb)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: source-bit table, in-flight word queue, edge counter.
    typedef struct {
        logic [7:0] d;
        int         acc;
    } ent_t;

    ent_t q[$];
    int   map8[8];
    int   cyc = 0;

    // SDES EP mapping: outputs 0..7 take input bits 3,0,1,2,1,2,3,0.
    function automatic void set_default();
        map8 = '{3, 0, 1, 2, 1, 2, 3, 0};
    endfunction

    function automatic logic [7:0] model_perm(input logic [3:0] s);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[k] = (map8[k] < 4) ? s[map8[k]] : 1'b0;
        end
        return r;
    endfunction

    function automatic bit exp_ready();
        return (q.size() < 2) || (ifa.i_ready == 1'b1);
    endfunction

    // A word becomes visible one full edge after the edge that accepted it.
    function automatic bit exp_valid();
        return (q.size() > 0) && (cyc >= q[0].acc + 1);
    endfunction

    // Advance one clock: update the model from the driven inputs, return at negedge.
    task automatic tick();
        bit   acc;
        bit   take;
        ent_t e;
        acc  = (ifa.i_valid == 1'b1) && exp_ready();
        take = exp_valid() && (ifa.i_ready == 1'b1);
        @(posedge clk);
        if (rst) begin
            q.delete();
            set_default();
        end else begin
            if (take) void'(q.pop_front());
            if (acc) begin
                e.d   = model_perm(ifa.i_signal);
                e.acc = cyc + 1;
                q.push_back(e);
            end
            if (ifa.i_cfg_restore) set_default();
            else if (ifa.i_cfg_we) map8[ifa.i_cfg_idx] = int'(ifa.i_cfg_sel);
        end
        cyc++;
        @(negedge clk);
        ifa.i_cfg_we = 1'b0;
        ifa.i_cfg_restore = 1'b0;
        ifb.i_cfg_we = 1'b0;
        ifb.i_cfg_restore = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        #1;
        vectors++; if (ifa.o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", ifa.o_valid); end
        vectors++; if (ifa.o_signal !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", ifa.o_signal); end
        vectors++; if (ifa.o_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", ifa.o_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_default();
        ifa.i_ready = 1'b1;
        ifa.i_valid = 1'b1; ifa.i_signal = 4'b1010;
        #1;
        vectors++; if (ifa.o_ready !== 1'b1) begin miscompares++; $display("FAIL default_ready: got %b want 1", ifa.o_ready); end
        tick();
        ifa.i_valid = 1'b0;
        #1;
        vectors++; if (ifa.o_valid !== 1'b0) begin miscompares++; $display("FAIL default_early: got %b want 0", ifa.o_valid); end
        tick();
        #1;
        vectors++; if (ifa.o_valid !== 1'b1) begin miscompares++; $display("FAIL default_valid: got %b want 1", ifa.o_valid); end
        vectors++; if (ifa.o_signal !== 8'h55) begin miscompares++; $display("FAIL default_data: got %h want 55", ifa.o_signal); end
        tick();
        #1;
        vectors++; if (ifa.o_valid !== 1'b0) begin miscompares++; $display("FAIL default_oneshot: got %b want 0", ifa.o_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ins [3];
        logic [7:0] exps[3];
        ins  = '{4'b0001, 4'b1111, 4'b0000};
        exps = '{8'h82, 8'hFF, 8'h00};
        ifa.i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ifa.i_valid  = (i < 3);
            ifa.i_signal = (i < 3) ? ins[i] : 4'b0000;
            #1;
            if (i < 3) begin
                vectors++; if (ifa.o_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, ifa.o_ready); end
            end
            if (i >= 2) begin
                vectors++; if (ifa.o_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, ifa.o_valid); end
                vectors++; if (ifa.o_signal !== exps[i-2]) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h want %h", i, ifa.o_signal, exps[i-2]); end
            end
            tick();
        end
        ifa.i_valid = 1'b0;
    endtask

    task automatic test_table_write();
        for (int k = 0; k < 8; k++) begin
            ifa.i_cfg_we  = 1'b1;
            ifa.i_cfg_idx = 3'(k);
            ifa.i_cfg_sel = 2'(k % 4);
            tick();
        end
        ifa.i_valid = 1'b1; ifa.i_signal = 4'b1010;
        tick();
        ifa.i_valid = 1'b0;
        tick();
        #1;
        vectors++; if (ifa.o_signal !== 8'hAA) begin miscompares++; $display("FAIL table_write: got %h want AA", ifa.o_signal); end
        tick();
    endtask

    task automatic test_same_cycle();
        ifa.i_cfg_we = 1'b1; ifa.i_cfg_idx = 3'd0; ifa.i_cfg_sel = 2'd1;
        ifa.i_valid = 1'b1; ifa.i_signal = 4'b1010;
        tick();
        tick();
        ifa.i_valid = 1'b0;
        #1;
        vectors++; if (ifa.o_signal !== 8'hAA) begin miscompares++; $display("FAIL same_cycle_old: got %h want AA", ifa.o_signal); end
        tick();
        #1;
        vectors++; if (ifa.o_signal !== 8'hAB) begin miscompares++; $display("FAIL same_cycle_new: got %h want AB", ifa.o_signal); end
        tick();
    endtask

    task automatic test_restore();
        ifa.i_cfg_restore = 1'b1;
        ifa.i_cfg_we = 1'b1; ifa.i_cfg_idx = 3'd2; ifa.i_cfg_sel = 2'd3;
        tick();
        ifa.i_valid = 1'b1; ifa.i_signal = 4'b1010;
        tick();
        ifa.i_valid = 1'b0;
        tick();
        #1;
        vectors++; if (ifa.o_signal !== 8'h55) begin miscompares++; $display("FAIL restore: got %h want 55", ifa.o_signal); end
        tick();
    endtask

    task automatic test_stall();
        ifa.i_ready = 1'b0;
        ifa.i_valid = 1'b1; ifa.i_signal = 4'b0001;
        #1;
        vectors++; if (ifa.o_ready !== 1'b1) begin miscompares++; $display("FAIL stall_acc1: got %b want 1", ifa.o_ready); end
        tick();
        ifa.i_signal = 4'b1111;
        #1;
        vectors++; if (ifa.o_ready !== 1'b1) begin miscompares++; $display("FAIL stall_acc2: got %b want 1", ifa.o_ready); end
        tick();
        ifa.i_signal = 4'b1010;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++; if (ifa.o_ready !== 1'b0) begin miscompares++; $display("FAIL stall_full[%0d]: got %b want 0", i, ifa.o_ready); end
            vectors++; if (ifa.o_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b want 1", i, ifa.o_valid); end
            vectors++; if (ifa.o_signal !== 8'h82) begin miscompares++; $display("FAIL stall_hold[%0d]: got %h want 82", i, ifa.o_signal); end
            tick();
        end
        ifa.i_ready = 1'b1;
        #1;
        vectors++; if (ifa.o_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release: got %b want 1", ifa.o_ready); end
        vectors++; if (ifa.o_signal !== 8'h82) begin miscompares++; $display("FAIL stall_out1: got %h want 82", ifa.o_signal); end
        tick();
        ifa.i_valid = 1'b0;
        #1;
        vectors++; if (ifa.o_signal !== 8'hFF) begin miscompares++; $display("FAIL stall_out2: got %h want FF", ifa.o_signal); end
        tick();
        #1;
        vectors++; if (ifa.o_valid !== 1'b1 || ifa.o_signal !== 8'h55) begin miscompares++; $display("FAIL stall_out3: got %b/%h want 1/55", ifa.o_valid, ifa.o_signal); end
        tick();
        #1;
        vectors++; if (ifa.o_valid !== 1'b0) begin miscompares++; $display("FAIL stall_drained: got %b want 0", ifa.o_valid); end
    endtask

    task automatic test_narrow();
        ifb.i_ready = 1'b1;
        ifb.i_cfg_we = 1'b1; ifb.i_cfg_idx = 3'd0; ifb.i_cfg_sel = 2'd3;
        tick();
        ifb.i_valid = 1'b1; ifb.i_signal = 3'b111;
        tick();
        ifb.i_signal = 3'b101;
        tick();
        ifb.i_valid = 1'b0;
        #1;
        vectors++; if (ifb.o_valid !== 1'b1 || ifb.o_signal !== 6'h3E) begin miscompares++; $display("FAIL narrow_sel_oob: got %b/%h want 1/3e", ifb.o_valid, ifb.o_signal); end
        tick();
        #1;
        vectors++; if (ifb.o_signal !== 6'h2C) begin miscompares++; $display("FAIL narrow_pattern: got %h want 2c", ifb.o_signal); end
        tick();
        ifb.i_cfg_we = 1'b1; ifb.i_cfg_idx = 3'd7; ifb.i_cfg_sel = 2'd3;
        tick();
        ifb.i_valid = 1'b1; ifb.i_signal = 3'b111;
        tick();
        ifb.i_valid = 1'b0;
        tick();
        #1;
        vectors++; if (ifb.o_valid !== 1'b1 || ifb.o_signal !== 6'h3E) begin miscompares++; $display("FAIL narrow_idx_oob: got %b/%h want 1/3e", ifb.o_valid, ifb.o_signal); end
        tick();
    endtask

    task automatic test_reset_midstream();
        ifa.i_cfg_we = 1'b1; ifa.i_cfg_idx = 3'd1; ifa.i_cfg_sel = 2'd1;
        ifa.i_ready = 1'b0;
        ifa.i_valid = 1'b1; ifa.i_signal = 4'b1111;
        tick();
        tick();
        ifa.i_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vectors++; if (ifa.o_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid: got %b want 0", ifa.o_valid); end
        vectors++; if (ifa.o_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_ready: got %b want 1", ifa.o_ready); end
        ifa.i_ready = 1'b1;
        ifa.i_valid = 1'b1; ifa.i_signal = 4'b1010;
        tick();
        ifa.i_valid = 1'b0;
        tick();
        #1;
        vectors++; if (ifa.o_valid !== 1'b1 || ifa.o_signal !== 8'h55) begin miscompares++; $display("FAIL midreset_table: got %b/%h want 1/55", ifa.o_valid, ifa.o_signal); end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            ifa.i_valid  = ($urandom_range(0, 3) != 0);
            ifa.i_signal = 4'($urandom);
            ifa.i_ready  = ($urandom_range(0, 3) != 0);
            ifa.i_cfg_we = ($urandom_range(0, 9) == 0);
            ifa.i_cfg_idx = 3'($urandom);
            ifa.i_cfg_sel = 2'($urandom);
            ifa.i_cfg_restore = ($urandom_range(0, 29) == 0);
            #1;
            vectors++; if (ifa.o_ready !== exp_ready()) begin miscompares++; $display("FAIL rand_ready@%0d: got %b want %b", n, ifa.o_ready, exp_ready()); end
            vectors++; if (ifa.o_valid !== exp_valid()) begin miscompares++; $display("FAIL rand_valid@%0d: got %b want %b", n, ifa.o_valid, exp_valid()); end
            if (exp_valid()) begin
                vectors++; if (ifa.o_signal !== q[0].d) begin miscompares++; $display("FAIL rand_data@%0d: got %h want %h", n, ifa.o_signal, q[0].d); end
            end
            tick();
        end
        ifa.i_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ifa.i_cfg_we = 1'b0; ifa.i_cfg_idx = '0; ifa.i_cfg_sel = '0; ifa.i_cfg_restore = 1'b0;
        ifa.i_valid = 1'b0; ifa.i_signal = '0; ifa.i_ready = 1'b1;
        ifb.i_cfg_we = 1'b0; ifb.i_cfg_idx = '0; ifb.i_cfg_sel = '0; ifb.i_cfg_restore = 1'b0;
        ifb.i_valid = 1'b0; ifb.i_signal = '0; ifb.i_ready = 1'b1;
        set_default();
        @(negedge clk);
        test_reset();
        test_default();
        test_back_to_back();
        test_table_write();
        test_same_cycle();
        test_restore();
        test_stall();
        test_narrow();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/permutation_engine.md
Name: permutation_engine

Overview:
- Parametrised, runtime-programmable bit-permutation/expansion engine; next generation of the fixed SDES EP/P4/P8/IP mappings.
- Each output bit selects any input bit through a per-bit select table. The table resets to a parameter default and can be rewritten through a config port.
- Two-stage valid/ready pipeline, full throughput, sits between round-function stages in the SDES datapath.
- Defaults reproduce the SDES EP mapping (4 -> 8).

Parameters:
- IN_W, 4, input width in bits (>=2).
- OUT_W, 8, output width in bits (>=1).
- SEL_W, $clog2(IN_W), select-field width; derived, not overridden.
- IDX_W, (OUT_W>1 ? $clog2(OUT_W) : 1), config index width; derived.
- DEFAULT_MAP, 16'h3993, OUT_W*SEL_W-bit reset table; entry k = DEFAULT_MAP[k*SEL_W +: SEL_W] = source bit for o_signal[k].

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_cfg_we  in  1  table write strobe.
- i_cfg_idx  in  IDX_W  output-bit index to write.
- i_cfg_sel  in  SEL_W  source input bit for that index.
- i_cfg_restore  in  1  reload entire table from DEFAULT_MAP.
- i_valid  in  1  input word valid.
- o_ready  out  1  engine can accept input.
- i_signal  in  IN_W  input word.
- o_valid  out  1  output word valid.
- i_ready  in  1  downstream accepts output.
- o_signal  out  OUT_W  permuted output word.

Behaviour:
- Reset (i_rst high at posedge): table <= DEFAULT_MAP; both stage valids <= 0; stage data and o_signal <= 0; o_valid = 0.
- Table: OUT_W registers of SEL_W bits.
- i_cfg_restore has priority over i_cfg_we in the same cycle.
- A write with i_cfg_idx >= OUT_W is ignored.
- An entry with sel >= IN_W is stored as written; the corresponding output bit then evaluates to 0.
- Stage A (permute): on accept (i_valid && o_ready), A_data[k] <= i_signal[table[k]] using the table value before this edge. A config write in the same cycle affects only words accepted from the next cycle on; in-flight words never change.
- Stage B (output): holds o_signal/o_valid. Contents are stable while o_valid && !i_ready.
- Handshake:
  - B advances when !B_valid || i_ready.
  - A advances into B when A_valid and B advances.
  - o_ready = !A_valid || B advances (combinational from i_ready; no combinational path from i_valid).
  - o_valid stays high until taken, with no bubble when i_ready is held high.
- Latency: word accepted at edge t is presented on o_signal after edge t+1 (visible cycle t+1 -> 2-register pipeline). Throughput is 1 word/cycle.
- Capacity: 2 words. With i_ready low, exactly two words are accepted, then o_ready falls.
- Simultaneous accept and output on a full pipeline: both transfers occur; occupancy is unchanged.
- Reset mid-stream: in-flight words are discarded, valids clear, and the table reverts to default. No output handshake completes at the reset edge.
- No X propagation: all registers reset.

Test Plan:
- Reset, default table, i_signal=4'b1010 with i_ready=1 -> o_signal=8'h55 two edges after accept, o_valid one cycle.
- Default table, i_signal=4'b0001 -> 8'h82; then 4'b1111 -> 8'hFF and 4'b0000 -> 8'h00 back-to-back, one output per cycle, no gaps.
- Write table k -> k%4 for k=0..7, then i_signal=4'b1010 -> 8'hAA.
- Same-cycle write + accept uses the old table.
- i_cfg_restore -> 8'h55 again.
- i_ready=0, drive 3 valid words -> first two accepted, o_ready=0 on third, o_signal holds first word stable.
- Raise i_ready -> words emerge in order, third accepted the same cycle.
- Write i_cfg_idx=0, sel value >= IN_W (param IN_W=3, SEL_W=2, sel=3) -> o_signal[0]=0.
- Write with idx >= OUT_W (OUT_W=6, idx=7) -> table unchanged.
- Assert i_rst with 2 words in flight and a modified table -> o_valid=0 next cycle, o_ready=1, subsequent 4'b1010 -> 8'h55.
